// File: rtl/aibcr3_dll_pkg.sv
// Shared widths, state/direction encodings and gray-code helpers for the DLL delay-code controller.
package aibcr3_dll_pkg;

  localparam int CODE_W = 10;
  localparam int CRS_W  = 7;
  localparam int FIN_W  = 3;

  typedef enum logic [1:0] {IDLE, SEARCH, TRACK, OVRD} dll_state_t;
  typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DN} dll_dir_t;

  function automatic logic [CRS_W-1:0] bin2gray(input logic [CRS_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Packs {gray(coarse), gray(fine)}; fine is zero-extended so its gray is the low bits.
  function automatic logic [CODE_W-1:0] code_gray(input logic [CODE_W-1:0] c);
    return {bin2gray(c[CODE_W-1:FIN_W]), FIN_W'(bin2gray(CRS_W'(c[FIN_W-1:0])))};
  endfunction

endpackage

// File: rtl/aibcr3_dll_step_timer.sv
// Loadable down-counter: sample pulses SETTLE_CYC cycles after the load edge.
module aibcr3_dll_step_timer #(
  parameter int SETTLE_CYC = 8
) (
  input  logic CK,
  input  logic RST,
  input  logic load,
  output logic sample
);

  logic [7:0] cnt;

  always_ff @(posedge CK or posedge RST) begin
    if (RST)
      cnt <= 8'd0;
    else if (load)
      cnt <= 8'(SETTLE_CYC);
    else if (cnt != 8'd0)
      cnt <= cnt - 8'd1;
  end

  assign sample = (cnt == 8'd1);

endmodule

// File: rtl/aibcr3_dll_code_ctrl.sv
// DLL delay-code controller: successive-approximation search, then +/-1 tracking with lock.
// Optional override port pair enabled by defining AIBCR3_DLL_CODE_OVRD_EN.
module aibcr3_dll_code_ctrl
  import aibcr3_dll_pkg::*;
#(
  parameter int SETTLE_CYC = 8,
  parameter int LOCK_CNT   = 4
) (
  input  logic              CK,
  input  logic              RST,
  input  logic              dll_en,
  input  logic              pd_up,
  input  logic              pd_dn,
`ifdef AIBCR3_DLL_CODE_OVRD_EN
  input  logic              ovrd_en,
  input  logic [CODE_W-1:0] ovrd_code,
`endif
  output logic [CRS_W-1:0]  sm_grey,
  output logic [FIN_W-1:0]  sm_igray,
  output logic              code_valid,
  output logic              dll_busy,
  output logic              dll_lock
);

  dll_state_t        state;
  dll_dir_t          last_dir;
  dll_dir_t          move;
  logic [CODE_W-1:0] code;
  logic [CODE_W-1:0] trial_code;
  logic [CODE_W-1:0] step_code;
  logic [3:0]        bit_idx;
  logic [3:0]        trial_idx;
  logic [3:0]        rev_cnt;
  logic [3:0]        rev_inc;
  logic              launch;
  logic              sample;
  logic              timer_load;

  // A step starts on the enabling edge out of IDLE and on every edge after a sample.
  always_comb begin
    timer_load = dll_en && ((state == IDLE) ||
                            (((state == SEARCH) || (state == TRACK)) && launch));
`ifdef AIBCR3_DLL_CODE_OVRD_EN
    if (ovrd_en)
      timer_load = 1'b0;
`endif
  end

  aibcr3_dll_step_timer #(.SETTLE_CYC(SETTLE_CYC)) u_timer (
    .CK     (CK),
    .RST    (RST),
    .load   (timer_load),
    .sample (sample)
  );

  always_comb begin
    trial_idx  = bit_idx - 4'd1;
    trial_code = code | (CODE_W'(1) << trial_idx);
    move       = DIR_NONE;
    step_code  = code;
    if (pd_up && !pd_dn && (code != '1)) begin
      move      = DIR_UP;
      step_code = code + CODE_W'(1);
    end else if (pd_dn && !pd_up && (code != '0)) begin
      move      = DIR_DN;
      step_code = code - CODE_W'(1);
    end
    rev_inc = (rev_cnt >= 4'(LOCK_CNT)) ? rev_cnt : rev_cnt + 4'd1;
  end

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      last_dir   <= DIR_NONE;
      code       <= '0;
      bit_idx    <= 4'd0;
      rev_cnt    <= 4'd0;
      launch     <= 1'b0;
      sm_grey    <= '0;
      sm_igray   <= '0;
      code_valid <= 1'b0;
      dll_busy   <= 1'b0;
      dll_lock   <= 1'b0;
    end else begin
      code_valid <= 1'b0;
`ifdef AIBCR3_DLL_CODE_OVRD_EN
      if (ovrd_en) begin
        state    <= OVRD;
        dll_busy <= 1'b0;
        dll_lock <= 1'b0;
        launch   <= 1'b0;
        if ((state != OVRD) || (ovrd_code != code)) begin
          code                <= ovrd_code;
          {sm_grey, sm_igray} <= code_gray(ovrd_code);
          code_valid          <= 1'b1;
        end
      end else
`endif
      if (!dll_en) begin
        state    <= IDLE;
        dll_busy <= 1'b0;
        dll_lock <= 1'b0;
        launch   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state               <= SEARCH;
            code                <= CODE_W'(1) << (CODE_W - 1);
            bit_idx             <= 4'(CODE_W - 1);
            {sm_grey, sm_igray} <= code_gray(CODE_W'(1) << (CODE_W - 1));
            code_valid          <= 1'b1;
            dll_busy            <= 1'b1;
            dll_lock            <= 1'b0;
            rev_cnt             <= 4'd0;
            last_dir            <= DIR_NONE;
            launch              <= 1'b0;
          end
          SEARCH: begin
            if (launch) begin
              launch              <= 1'b0;
              bit_idx             <= trial_idx;
              code                <= trial_code;
              {sm_grey, sm_igray} <= code_gray(trial_code);
              code_valid          <= 1'b1;
            end else if (sample) begin
              launch <= 1'b1;
              if (!pd_up)
                code[bit_idx] <= 1'b0;
              if (bit_idx == 4'd0) begin
                state    <= TRACK;
                dll_busy <= 1'b0;
              end
            end
          end
          TRACK: begin
            // Strobe only when the code differs from what downstream already holds.
            if (launch) begin
              launch <= 1'b0;
              if (code_gray(code) != {sm_grey, sm_igray}) begin
                {sm_grey, sm_igray} <= code_gray(code);
                code_valid          <= 1'b1;
              end
            end else if (sample) begin
              launch <= 1'b1;
              if (move != DIR_NONE) begin
                code     <= step_code;
                last_dir <= move;
                if ((last_dir != DIR_NONE) && (move != last_dir)) begin
                  rev_cnt <= rev_inc;
                  if (rev_inc >= 4'(LOCK_CNT))
                    dll_lock <= 1'b1;
                end else if (move == last_dir) begin
                  rev_cnt  <= 4'd0;
                  dll_lock <= 1'b0;
                end
              end
            end
          end
          default: begin
            state    <= IDLE;
            dll_busy <= 1'b0;
            dll_lock <= 1'b0;
            launch   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_aibcr3_dll_code_ctrl.sv
// Self-checking bench for aibcr3_dll_code_ctrl: table vectors, random PD sessions, reset and override cases.
module tb_aibcr3_dll_code_ctrl;

  localparam int S    = 8;
  localparam int P    = S + 1;
  localparam int LOCK = 4;

  logic       CK = 1'b0;
  logic       RST;
  logic       dll_en;
  logic       pd_up;
  logic       pd_dn;
  logic [6:0] sm_grey;
  logic [2:0] sm_igray;
  logic       code_valid;
  logic       dll_busy;
  logic       dll_lock;
`ifdef AIBCR3_DLL_CODE_OVRD_EN
  logic       ovrd_en;
  logic [9:0] ovrd_code;
`endif

  always #5 CK = ~CK;

  aibcr3_dll_code_ctrl #(.SETTLE_CYC(S), .LOCK_CNT(LOCK)) dut (
    .CK         (CK),
    .RST        (RST),
    .dll_en     (dll_en),
    .pd_up      (pd_up),
    .pd_dn      (pd_dn),
`ifdef AIBCR3_DLL_CODE_OVRD_EN
    .ovrd_en    (ovrd_en),
    .ovrd_code  (ovrd_code),
`endif
    .sm_grey    (sm_grey),
    .sm_igray   (sm_igray),
    .code_valid (code_valid),
    .dll_busy   (dll_busy),
    .dll_lock   (dll_lock)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: code under test, code last presented, last move, reversals, lock.
  int   m_code;
  int   m_shown;
  int   m_dir;
  int   m_rev;
  logic m_lock;
  logic saw_lock;
  logic [6:0] snap_grey;
  logic [2:0] snap_igray;

  typedef struct {
    int         mode;
    int         thr;
    int         n_edges;
    logic [6:0] grey;
    logic [2:0] igray;
    logic       lock;
  } vec_t;

  vec_t vecs[3];

  function automatic logic [12:0] expVec(input logic cv, input logic busy, input logic lock,
                                         input int code);
    logic [6:0] c;
    logic [2:0] f;
    c = 7'(code >> 3);
    f = 3'(code);
    return {cv, busy, lock, c ^ (c >> 1), f ^ (f >> 1)};
  endfunction

  function automatic logic [12:0] dutVec();
    return {code_valid, dll_busy, dll_lock, sm_grey, sm_igray};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drives the PD inputs for the upcoming edge; outside sample edges they are random noise.
  task automatic applyStimulus(input int mode, input int thr, input int e_next);
    int m;
    m = e_next / P;
    if ((e_next % P) == S) begin
      case (mode)
        0: begin pd_up = 1'b1; pd_dn = 1'b0; end
        1: begin pd_up = 1'b0; pd_dn = 1'b1; end
        3: begin pd_up = 1'($urandom); pd_dn = 1'($urandom); end
        4: begin
          if (m == 16 || m == 17) begin
            pd_up = 1'b1; pd_dn = 1'b0;
          end else begin
            pd_up = (m_code < thr); pd_dn = !(m_code < thr);
          end
        end
        default: begin pd_up = (m_code < thr); pd_dn = !(m_code < thr); end
      endcase
    end else begin
      pd_up = 1'($urandom);
      pd_dn = 1'($urandom);
    end
  endtask

  task automatic runSession(input int mode, input int thr, input int n_edges);
    int m, ph, d;
    logic cv;
    dll_en   = 1'b1;
    m_code   = 0;
    m_dir    = 0;
    m_rev    = 0;
    m_lock   = 1'b0;
    saw_lock = 1'b0;
    applyStimulus(mode, thr, 0);
    for (int e = 0; e < n_edges; e++) begin
      @(posedge CK);
      m  = e / P;
      ph = e % P;
      cv = 1'b0;
      if (ph == 0) begin
        if (m < 10) begin
          m_code = m_code + (1 << (9 - m));
          cv = 1'b1;
        end else begin
          cv = (m_code != m_shown);
        end
        m_shown = m_code;
      end else if (ph == S) begin
        if (m < 10) begin
          if (!pd_up) m_code = m_code - (1 << (9 - m));
        end else begin
          d = (pd_up && !pd_dn) ? 1 : ((pd_dn && !pd_up) ? -1 : 0);
          if (m_code + d < 0 || m_code + d > 1023) d = 0;
          if (d != 0) begin
            if (m_dir == -d) begin
              if (m_rev < LOCK) m_rev++;
              if (m_rev == LOCK) m_lock = 1'b1;
            end else if (m_dir == d) begin
              m_rev  = 0;
              m_lock = 1'b0;
            end
            m_code = m_code + d;
            m_dir  = d;
          end
        end
      end
      @(negedge CK);
      checkOutput($sformatf("mode%0d_edge%0d", mode, e), 32'(dutVec()),
                  32'(expVec(cv, (e < 9 * P + S), m_lock, m_shown)));
      if (dll_lock) saw_lock = 1'b1;
      if (e == 10 * P) begin
        snap_grey  = sm_grey;
        snap_igray = sm_igray;
      end
      applyStimulus(mode, thr, e + 1);
    end
  endtask

  task automatic restIdle(input int n);
    dll_en = 1'b0;
    m_lock = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge CK);
      @(negedge CK);
      checkOutput("idle_hold", 32'(dutVec()), 32'(expVec(1'b0, 1'b0, 1'b0, m_shown)));
      pd_up = 1'($urandom);
      pd_dn = 1'($urandom);
    end
  endtask

  initial begin
    int mode, thr, n, res;
    RST     = 1'b1;
    dll_en  = 1'b0;
    pd_up   = 1'b0;
    pd_dn   = 1'b0;
    m_shown = 0;
`ifdef AIBCR3_DLL_CODE_OVRD_EN
    ovrd_en   = 1'b0;
    ovrd_code = 10'h0;
`endif
    @(negedge CK);
    checkOutput("reset_state", 32'(dutVec()), 32'h0);
    RST = 1'b0;
    restIdle(2);

    vecs[0] = '{0,   0, 14 * P, 7'h40, 3'h4, 1'b0};
    vecs[1] = '{1,   0, 14 * P, 7'h00, 3'h0, 1'b0};
    vecs[2] = '{2, 300, 16 * P, 7'h37, 3'h2, 1'b1};
    for (int i = 0; i < 3; i++) begin
      runSession(vecs[i].mode, vecs[i].thr, vecs[i].n_edges);
      checkOutput($sformatf("tbl%0d_grey", i), 32'(snap_grey), 32'(vecs[i].grey));
      checkOutput($sformatf("tbl%0d_igray", i), 32'(snap_igray), 32'(vecs[i].igray));
      checkOutput($sformatf("tbl%0d_lock", i), 32'(dll_lock), 32'(vecs[i].lock));
      restIdle(3);
    end

    // Lock, one more dither step, then two forced up-steps clear lock and land on 301.
    runSession(4, 300, 19 * P);
    checkOutput("lock_seen", 32'(saw_lock), 32'h1);
    checkOutput("lock_drop", 32'(dll_lock), 32'h0);
    checkOutput("final_301", 32'({sm_grey, sm_igray}), 32'({7'h37, 3'h7}));
    restIdle(2);

    for (int r = 0; r < 6; r++) begin
      mode = (r % 2 == 1) ? 3 : 2;
      thr  = int'($urandom_range(0, 1024));
      n    = int'($urandom_range(3, 25 * P));
      runSession(mode, thr, n);
      if (mode == 2 && n > 10 * P) begin
        res = (thr < 1) ? 0 : ((thr > 1024) ? 1023 : thr - 1);
        checkOutput($sformatf("search_thr%0d", thr), 32'({snap_grey, snap_igray}),
                    32'(expVec(1'b0, 1'b0, 1'b0, res) & 13'h3FF));
      end
      restIdle(2);
    end

    // Asynchronous reset in the middle of the fifth search step.
    runSession(0, 0, 4 * P + 3);
    @(posedge CK);
    #2 RST = 1'b1;
    #1 checkOutput("rst_async", 32'(dutVec()), 32'h0);
    m_shown = 0;
    @(negedge CK);
    RST = 1'b0;
    checkOutput("rst_release", 32'(dutVec()), 32'h0);
    runSession(0, 0, 2 * P);
    restIdle(2);

`ifdef AIBCR3_DLL_CODE_OVRD_EN
    ovrd_code = 10'h155;
    ovrd_en   = 1'b1;
    @(posedge CK);
    @(negedge CK);
    checkOutput("ovrd_entry", 32'(dutVec()), 32'(expVec(1'b1, 1'b0, 1'b0, 'h155)));
    @(posedge CK);
    @(negedge CK);
    checkOutput("ovrd_hold", 32'(dutVec()), 32'(expVec(1'b0, 1'b0, 1'b0, 'h155)));
    ovrd_code = 10'h2A3;
    @(posedge CK);
    @(negedge CK);
    checkOutput("ovrd_change", 32'(dutVec()), 32'(expVec(1'b1, 1'b0, 1'b0, 'h2A3)));
    ovrd_en = 1'b0;
    m_shown = 'h2A3;
    restIdle(2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/aibcr3_dll_code_ctrl.md
# aibcr3_dll_code_ctrl

DLL delay-code controller that sequences the coarse/fine delay code feeding the DLL code mux and its capture flops. It runs a successive-approximation search on a phase-detector decision, then tracks with ±1 steps and flags lock. It presents the 7-bit coarse and 3-bit interpolator codes in gray form (`sm_grey`, `sm_igray`), strobed by `code_valid`, in the `CK` domain.

## Interface
- `SETTLE_CYC`, 8: cycles from a `code_valid` pulse to the phase-detector sample; legal 2..255.
- `LOCK_CNT`, 4: consecutive tracking direction reversals required to assert lock; legal 1..15.
- `CK` in 1: DLL controller clock; all logic on rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `dll_en` in 1: level; high runs search then track, low returns to idle.
- `pd_up` in 1: phase detector says increase delay; already synchronous to `CK`.
- `pd_dn` in 1: phase detector says decrease delay; already synchronous to `CK`.
- `sm_grey` out 7: gray(coarse code), coarse = code[9:3].
- `sm_igray` out 3: gray(fine code), fine = code[2:0].
- `code_valid` out 1: one-cycle strobe; new `sm_grey`/`sm_igray` are valid in that cycle and held until the next strobe.
- `dll_busy` out 1: high while in SEARCH.
- `dll_lock` out 1: tracking lock indicator.

## Operation
Internal state is a 10-bit binary `code`. Outputs are `sm_grey = bin2gray(code[9:3])` and `sm_igray = bin2gray(code[2:0])`, both registered.

**States**
- IDLE
  - `code` holds its last value; `dll_lock`=0.
  - `dll_en` high: clear `code`, set the trial bit `k`=9, go to SEARCH.
- SEARCH (successive approximation)
  - Each step sets trial bit `code[k]`=1, pulses `code_valid`, and waits `SETTLE_CYC`.
  - It then samples `pd_up`. If `pd_up`=1, bit `k` is kept; otherwise it is cleared.
  - After `k`=0, go to TRACK. The final code is not re-strobed if bit 0 was cleared; its `code_valid` is issued on the first TRACK step.
- TRACK
  - Every step period, sample the decision:
    - `pd_up` only: `code`+1, saturating at 1023.
    - `pd_dn` only: `code`−1, saturating at 0.
    - both or neither: hold.
  - `code_valid` pulses only when `code` actually changes.
  - Reversal counter:
    - increments when a move is opposite to the previous move;
    - clears on two consecutive moves in the same direction;
    - a hold leaves it unchanged.
  - `dll_lock` sets when the counter reaches `LOCK_CNT` and clears when the counter clears. The counter saturates.
- `dll_en` low in any state: go to IDLE next cycle, clear `dll_lock` and `dll_busy`, hold `code`, no strobe.

**Reset values:** `sm_grey`=0, `sm_igray`=0, `code_valid`=0, `dll_busy`=0, `dll_lock`=0, state IDLE, counters 0.

**`RST` mid-operation:** all outputs drop to reset values asynchronously. No strobe is issued on release.

## Timing
- `dll_en` sampled high at edge N: first `code_valid` (code 0x200, `sm_grey`=7'h60, `sm_igray`=0) is high in cycle N+1.
- Step period P = `SETTLE_CYC`+1. With `code_valid` at cycle t, the PD is sampled at t+`SETTLE_CYC` and the next step starts at t+P.
- SEARCH duration is 10·P cycles. `dll_busy` is high from N+1 through the last SEARCH sample.
- Minimum spacing between `code_valid` pulses is P. Downstream synchronizer latency (2 cycles) is absorbed because `SETTLE_CYC` ≥ 2.
- `pd_up`/`pd_dn` are ignored outside sample cycles.

## Configuration
- `AIBCR3_DLL_CODE_OVRD_EN` defined:
  - Adds ports `ovrd_en` (in 1) and `ovrd_code` (in 10).
  - `ovrd_en` high forces state OVRD from any state and loads `code`=`ovrd_code`.
  - `code_valid` pulses on entry and on every cycle where `ovrd_code` differs from `code`, applied next cycle.
  - `dll_lock`=0 and `dll_busy`=0 while in OVRD.
  - `ovrd_en` low: IDLE, then normal flow if `dll_en` is high.
- Not defined: no ports and no OVRD state.

## Structure
- Package `aibcr3_dll_pkg` holds:
  - `CODE_W`=10, `CRS_W`=7, `FIN_W`=3;
  - the state enum (IDLE, SEARCH, TRACK, OVRD);
  - the `bin2gray` function.
- Sub-module `aibcr3_dll_step_timer`: loadable down-counter producing the sample pulse `SETTLE_CYC` cycles after each step start.

## Test plan
- `pd_up`=1 constant, `dll_en` rise → 10 strobes at spacing P; final code 1023 gives `sm_grey`=7'h40, `sm_igray`=3'h4. TRACK then issues no strobes (saturated); `dll_lock`=0.
- `pd_up`=0, `pd_dn`=1 constant → SEARCH ends at code 0, first TRACK strobe shows `sm_grey`=0, `sm_igray`=0; saturation holds with no further strobes.
- Model `pd_up`=(code<300), `pd_dn`=!`pd_up` → search gives 299 (`sm_grey`=7'h37, `sm_igray`=3'h2). TRACK dithers 299↔300; `dll_lock` rises after the 4th reversal.
- From lock, force `pd_up`=1 for 2 steps → counter clears and `dll_lock` falls; code reaches 301.
- `RST` asserted during SEARCH step 5 → all outputs 0 immediately; after release with `dll_en` high, first strobe is code 0x200 one cycle later.
- `AIBCR3_DLL_CODE_OVRD_EN` build: `ovrd_en`=1, `ovrd_code`=10'h155 → strobe next cycle with `sm_grey`=gray(42)=7'h3F, `sm_igray`=gray(5)=3'h7.
